irq_controller: RTL

- Programmable interrupt controller between the timer and peripheral interrupt lines (T0_irq, T1_irq, and others) and the CPU exception logic.
- Latches sources into pending bits and applies per-source masks and a global enable.
- Picks the highest-priority pending source, raises a single request to the CPU, then runs an ack/end-of-interrupt (EOI) service handshake.
- Its registers are mapped into the CPU's peripheral bus space (PrAddr/Pr_WD/PrWe/Pr_RD style).

---
 rtl/irq_controller_pkg.sv | 28 ++
 rtl/irq_controller_if.sv | 26 ++
 rtl/irq_controller_prio_enc.sv | 19 +
 rtl/irq_controller.sv | 133 +++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants, register offsets and types for the interrupt controller.
package irq_controller_pkg;

  localparam int unsigned N_IRQ_DEF = 6;
  localparam int unsigned ID_W_DEF  = 3;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned DATA_W    = 32;

  localparam logic [ADDR_W-1:0] OFF_CTRL = 3'd0;
  localparam logic [ADDR_W-1:0] OFF_MASK = 3'd1;
  localparam logic [ADDR_W-1:0] OFF_PEND = 3'd2;
  localparam logic [ADDR_W-1:0] OFF_TRIG = 3'd3;
  localparam logic [ADDR_W-1:0] OFF_VEC  = 3'd4;
  localparam logic [ADDR_W-1:0] OFF_EOI  = 3'd5;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

  // One peripheral-bus write beat as seen by the controller.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } bus_wr_t;

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side bus and interrupt handshake of the interrupt controller.
interface irq_controller_if
  import irq_controller_pkg::*;
#(
  parameter int unsigned ID_W = ID_W_DEF
) ();

  logic [ADDR_W-1:0] pr_addr;
  logic              pr_we;
  logic [DATA_W-1:0] pr_wd;
  logic [DATA_W-1:0] pr_rd;
  logic              irq_out;
  logic [ID_W-1:0]   irq_id;
  logic              int_ack;

  modport master (
    output pr_addr, pr_we, pr_wd, int_ack,
    input  pr_rd, irq_out, irq_id
  );

  modport slave (
    input  pr_addr, pr_we, pr_wd, int_ack,
    output pr_rd, irq_out, irq_id
  );

endinterface

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
  parameter int unsigned N = 6,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] vec_i,
  output logic         any_c,
  output logic [W-1:0] id_c
);

  always_comb begin
    any_c = |vec_i;
    id_c  = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) id_c = W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Programmable interrupt controller: pending capture, masking, priority
// selection and an ack/EOI service handshake toward the CPU.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned N_IRQ = N_IRQ_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  irq_controller_if.slave  bus
);

  bus_wr_t wr;

  logic             gie_q,     gie_d;
  logic [N_IRQ-1:0] mask_q,    mask_d;
  logic [N_IRQ-1:0] pend_q,    pend_d;
  logic [N_IRQ-1:0] trig_q,    trig_d;
  logic [N_IRQ-1:0] irq_q,     irq_d;
  logic [ID_W-1:0]  isr_id_q,  isr_id_d;
  logic             irq_out_q, irq_out_d;
  logic [ID_W-1:0]  irq_id_q,  irq_id_d;
  state_e           state_q,   state_d;

  logic             wr_ctrl, wr_mask, wr_pend, wr_trig, wr_eoi;
  logic             ack_fire;
  logic [N_IRQ-1:0] rise, w1c, ack_clr, active;
  logic             any_c;
  logic [ID_W-1:0]  sel_c;
  logic [DATA_W-1:0] rd_c;
  logic             unused_wd;

  assign wr.we   = bus.pr_we;
  assign wr.addr = bus.pr_addr;
  assign wr.wd   = bus.pr_wd;

  assign unused_wd = ^wr.wd[DATA_W-1:N_IRQ];

  assign active = pend_q & mask_q;

  irq_prio_enc #(.N(N_IRQ), .W(ID_W)) u_prio (
    .vec_i (active),
    .any_c (any_c),
    .id_c  (sel_c)
  );

  // Next-state logic for registers, pending bits and the service FSM.
  always_comb begin
    wr_ctrl  = wr.we && (wr.addr == OFF_CTRL);
    wr_mask  = wr.we && (wr.addr == OFF_MASK);
    wr_pend  = wr.we && (wr.addr == OFF_PEND);
    wr_trig  = wr.we && (wr.addr == OFF_TRIG);
    wr_eoi   = wr.we && (wr.addr == OFF_EOI);
    ack_fire = bus.int_ack && irq_out_q && (state_q == IDLE);

    gie_d    = wr_ctrl ? wr.wd[0] : gie_q;
    mask_d   = wr_mask ? wr.wd[N_IRQ-1:0] : mask_q;
    trig_d   = wr_trig ? wr.wd[N_IRQ-1:0] : trig_q;
    irq_d    = irq_in;

    rise     = irq_in & ~irq_q;
    w1c      = wr_pend ? wr.wd[N_IRQ-1:0] : '0;
    ack_clr  = ack_fire ? (N_IRQ'(1) << irq_id_q) : '0;
    // Edge bits: a new rising edge beats any clear; level bits follow the line.
    pend_d   = (trig_q & ((pend_q & ~w1c & ~ack_clr) | rise)) |
               (~trig_q & irq_in);

    state_d  = state_q;
    isr_id_d = isr_id_q;
    case (state_q)
      IDLE: begin
        if (ack_fire) begin
          state_d  = SERVICE;
          isr_id_d = irq_id_q;
        end
      end
      SERVICE: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    irq_out_d = gie_q && (state_q == IDLE) && any_c && !ack_fire;
    irq_id_d  = sel_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gie_q     <= 1'b0;
      mask_q    <= '0;
      pend_q    <= '0;
      trig_q    <= '0;
      irq_q     <= '0;
      isr_id_q  <= '0;
      irq_out_q <= 1'b0;
      irq_id_q  <= '0;
      state_q   <= IDLE;
    end else begin
      gie_q     <= gie_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      trig_q    <= trig_d;
      irq_q     <= irq_d;
      isr_id_q  <= isr_id_d;
      irq_out_q <= irq_out_d;
      irq_id_q  <= irq_id_d;
      state_q   <= state_d;
    end
  end

  // Register read mux; unmapped offsets read zero.
  always_comb begin
    rd_c = '0;
    case (wr.addr)
      OFF_CTRL: rd_c[0]         = gie_q;
      OFF_MASK: rd_c[N_IRQ-1:0] = mask_q;
      OFF_PEND: rd_c[N_IRQ-1:0] = pend_q;
      OFF_TRIG: rd_c[N_IRQ-1:0] = trig_q;
      OFF_VEC: begin
        rd_c[ID_W-1:0]   = isr_id_q;
        rd_c[DATA_W-1]   = (state_q == SERVICE);
      end
      default: rd_c = '0;
    endcase
  end

  assign bus.pr_rd   = rd_c;
  assign bus.irq_out = irq_out_q;
  assign bus.irq_id  = irq_id_q;

endmodule
